// File: rtl/frame_overlap_buffer_if.sv
// rtl/frame_overlap_buffer_if.sv - sample-in / frame-out bus of the overlapping frame buffer
interface frame_overlap_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
    logic [15:0]       out_frame_idx;
    logic [ADDR_W:0]   level;
    logic              overflow;

    // master: capture-side source and frame sink; slave: the buffer itself
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_sof, out_eof, out_frame_idx, level, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_sof, out_eof, out_frame_idx, level, overflow
    );
endinterface

// File: rtl/frame_overlap_buffer.sv
// rtl/frame_overlap_buffer.sv - circular sample buffer emitting overlapping frames of FRAME_LEN with hop HOP_LEN
// Frames are read from a synchronous RAM with a one-sample prefetch so a ready sink gets one sample per clock.
module frame_overlap_buffer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 512,
    parameter int HOP_LEN   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_overlap_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;

    localparam logic [PW-1:0]     DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]     FRAME_P = PW'(FRAME_LEN);
    localparam logic [PW-1:0]     HOP_P   = PW'(HOP_LEN);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FRAME_LEN - 1);

    generate
        if (FRAME_LEN < 2 || HOP_LEN < 1 || HOP_LEN > FRAME_LEN || FRAME_LEN + HOP_LEN > DEPTH) begin : g_bad_params
            $error("frame_overlap_buffer: illegal FRAME_LEN/HOP_LEN for this DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        FILL = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     wp_q;
    logic [PW-1:0]     fs_q;
    logic [ADDR_W-1:0] rp_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_sof_q;
    logic              out_eof_q;
    logic [15:0]       frame_idx_q;
    logic              overflow_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic [PW-1:0]     level_d;
    logic              wr_en_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;

    assign level_d = wp_q - fs_q;
    assign wr_en_d = bus.in_valid && (level_d < DEPTH_P);

    // rd_data_q always holds the sample after the one on out_data while a frame is streaming
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = rp_q;
        case (state_q)
            READ: rd_en_d = 1'b1;
            OUT: begin
                if (!out_valid_q) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rp_q + ADDR_W'(1);
                end else if (bus.out_ready && !out_eof_q) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rp_q + ADDR_W'(2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[wp_q[ADDR_W-1:0]] <= bus.in_data;
        end
        if (rd_en_d) begin
            rd_data_q <= mem[rd_addr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            wp_q        <= '0;
            fs_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            frame_idx_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_en_d) begin
                wp_q <= wp_q + PW'(1);
            end
            if (bus.in_valid && !wr_en_d) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (level_d >= FRAME_P) begin
                        rp_q    <= fs_q[ADDR_W-1:0];
                        cnt_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: state_q <= OUT;
                OUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rd_data_q;
                        out_sof_q   <= (cnt_q == '0);
                        out_eof_q   <= (cnt_q == LAST_A);
                    end else if (bus.out_ready) begin
                        if (out_eof_q) begin
                            fs_q        <= fs_q + HOP_P;
                            frame_idx_q <= frame_idx_q + 16'd1;
                            out_valid_q <= 1'b0;
                            out_sof_q   <= 1'b0;
                            out_eof_q   <= 1'b0;
                            state_q     <= FILL;
                        end else begin
                            rp_q       <= rp_q + ADDR_W'(1);
                            cnt_q      <= cnt_q + ADDR_W'(1);
                            out_data_q <= rd_data_q;
                            out_sof_q  <= 1'b0;
                            out_eof_q  <= (cnt_q + ADDR_W'(1) == LAST_A);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_sof       = out_sof_q;
    assign bus.out_eof       = out_eof_q;
    assign bus.out_frame_idx = frame_idx_q;
    assign bus.level         = level_d;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_frame_overlap_buffer.sv
// tb/tb_frame_overlap_buffer.sv - self-checking bench for frame_overlap_buffer (hop 4 and hop 8 instances)
module tb_frame_overlap_buffer;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int FL = 8;

    typedef logic [33:0] rec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    rec_t got_a[$];
    rec_t got_b[$];
    rec_t exp_q[$];
    int   acc_q[$];

    always #5 clk = ~clk;

    frame_overlap_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    frame_overlap_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    frame_overlap_buffer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL), .HOP_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    frame_overlap_buffer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL), .HOP_LEN(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.out_ready = bus_a.out_ready;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus_a.out_valid && bus_a.out_ready)
                got_a.push_back({bus_a.out_frame_idx, bus_a.out_sof, bus_a.out_eof, bus_a.out_data});
            if (bus_b.out_valid && bus_b.out_ready)
                got_b.push_back({bus_b.out_frame_idx, bus_b.out_sof, bus_b.out_eof, bus_b.out_data});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish earlier");
        $fatal(1);
    end

    // Frame k covers accepted samples [k*hop, k*hop+FL); only complete frames are ever emitted.
    function automatic void build_exp(input int hop);
        exp_q.delete();
        for (int k = 0; k * hop + FL <= acc_q.size(); k++)
            for (int j = 0; j < FL; j++)
                exp_q.push_back({16'(k), j == 0, j == FL - 1, 16'(acc_q[k * hop + j])});
    endfunction

    task automatic step(input logic v, input logic [15:0] d, input logic r);
        bus_a.in_valid  = v;
        bus_a.in_data   = d;
        bus_a.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_a.delete();
        got_b.delete();
        acc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
        tests_run++;
        if ({bus_a.out_data, bus_a.out_valid, bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx,
             bus_a.level, bus_a.overflow} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_a: outputs %h, required all zero", {bus_a.out_data, bus_a.out_valid,
                     bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx, bus_a.level, bus_a.overflow});
        end
        tests_run++;
        if ({bus_b.out_data, bus_b.out_valid, bus_b.out_sof, bus_b.out_eof, bus_b.out_frame_idx,
             bus_b.level, bus_b.overflow} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_b: outputs %h, required all zero", {bus_b.out_data, bus_b.out_valid,
                     bus_b.out_sof, bus_b.out_eof, bus_b.out_frame_idx, bus_b.level, bus_b.overflow});
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(i), 1'b1);
            acc_q.push_back(i);
            if (i >= 7 && i <= 10) begin
                tests_run++;
                if (bus_a.out_valid !== (i == 10)) begin
                    tests_failed++;
                    $display("FAIL stream_latency: out_valid=%b %0d clk after 8th write, required %b",
                             bus_a.out_valid, i - 7, i == 10);
                end
            end
        end
        repeat (60) step(1'b0, 16'd0, 1'b1);
        build_exp(4);
        tests_run++;
        if (got_a.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL stream_count: %0d samples emitted, required %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            tests_run++;
            if (got_a[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stream_rec[%0d]: got %h, required %h", i, got_a[i], exp_q[i]);
            end
        end
        tests_run++;
        if (bus_a.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_overflow: overflow=%b, required 0", bus_a.overflow);
        end
    endtask

    task automatic test_backpressure();
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [34:0] snap;
        logic        stall;
        logic        r;
        do_reset();
        for (int c = 0; c < 140; c++) begin
            r     = pat[c % 4];
            snap  = {bus_a.out_data, bus_a.out_valid, bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx};
            stall = bus_a.out_valid && !r;
            if (c < 16) acc_q.push_back(c);
            step(c < 16, 16'(c), r);
            if (stall) begin
                tests_run++;
                if ({bus_a.out_data, bus_a.out_valid, bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx} !== snap) begin
                    tests_failed++;
                    $display("FAIL bp_stable cyc %0d: got %h, required %h", c,
                             {bus_a.out_data, bus_a.out_valid, bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx}, snap);
                end
            end
        end
        build_exp(4);
        tests_run++;
        if (got_a.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_count: %0d samples emitted, required %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            tests_run++;
            if (got_a[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_rec[%0d]: got %h, required %h", i, got_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int seen16;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i < 16) acc_q.push_back(i);
            if (i >= 15) begin
                tests_run++;
                if (bus_a.level !== 5'd16 || bus_a.overflow !== (i == 16)) begin
                    tests_failed++;
                    $display("FAIL ovf_after_%0d: level=%0d overflow=%b, required level=16 overflow=%b",
                             i + 1, bus_a.level, bus_a.overflow, i == 16);
                end
            end
        end
        repeat (80) step(1'b0, 16'd0, 1'b1);
        build_exp(4);
        tests_run++;
        if (got_a.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL ovf_count: %0d samples emitted, required %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            tests_run++;
            if (got_a[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL ovf_rec[%0d]: got %h, required %h", i, got_a[i], exp_q[i]);
            end
        end
        seen16 = 0;
        foreach (got_a[i]) if (got_a[i][15:0] == 16'd16) seen16++;
        tests_run++;
        if (seen16 !== 0 || bus_a.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_dropped: sample16 emitted %0d times overflow=%b, required 0 times overflow=1",
                     seen16, bus_a.overflow);
        end
    endtask

    task automatic test_non_overlap();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 16'(i), 1'b1);
            step(1'b0, 16'd0, 1'b1);
            acc_q.push_back(i);
        end
        repeat (60) step(1'b0, 16'd0, 1'b1);
        build_exp(8);
        tests_run++;
        if (got_b.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL nov_count: %0d samples emitted, required %0d", got_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            tests_run++;
            if (got_b[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL nov_rec[%0d]: got %h, required %h", i, got_b[i], exp_q[i]);
            end
        end
        tests_run++;
        if (bus_b.level !== 5'd0 || bus_b.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL nov_level: level=%0d overflow=%b, required 0 and 0", bus_b.level, bus_b.overflow);
        end
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        base = int'($urandom_range(0, 65535));
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 16'(base + i), 1'b1);
            acc_q.push_back((base + i) & 16'hffff);
            repeat ($urandom_range(2, 4)) step(1'b0, 16'd0, 1'b1);
        end
        repeat (60) step(1'b0, 16'd0, 1'b1);
        build_exp(4);
        tests_run++;
        if (got_a.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL wrap_count: %0d samples emitted, required %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            tests_run++;
            if (got_a[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL wrap_rec[%0d]: got %h, required %h", i, got_a[i], exp_q[i]);
            end
        end
        tests_run++;
        if (bus_a.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_overflow: overflow=%b, required 0", bus_a.overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int base;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (bus_a.out_valid && bus_a.out_frame_idx == 16'd1 && bus_a.out_data == 16'd7) begin
                rst = 1'b1;
                #1;
                found = 1'b1;
                tests_run++;
                if ({bus_a.out_data, bus_a.out_valid, bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx,
                     bus_a.level, bus_a.overflow} !== 41'd0) begin
                    tests_failed++;
                    $display("FAIL midrst_outputs: %h, required all zero", {bus_a.out_data, bus_a.out_valid,
                             bus_a.out_sof, bus_a.out_eof, bus_a.out_frame_idx, bus_a.level, bus_a.overflow});
                end
            end else begin
                step(c < 16, 16'(c), 1'b1);
            end
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL midrst_timeout: 4th sample of frame 1 not seen in 60 clk, required it to appear");
        end
        bus_a.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_a.delete();
        acc_q.delete();
        base = int'($urandom_range(0, 65535));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(base + i), 1'b1);
            acc_q.push_back((base + i) & 16'hffff);
        end
        repeat (30) step(1'b0, 16'd0, 1'b1);
        build_exp(4);
        tests_run++;
        if (got_a.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL midrst_count: %0d samples emitted, required %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            tests_run++;
            if (got_a[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL midrst_rec[%0d]: got %h, required %h", i, got_a[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_overflow();
        test_non_overlap();
        test_wrap();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
